branch_predictor: RTL

Parametrised dynamic branch predictor for the 5-stage pipeline. It replaces the static "predict not-taken, flush on resolve" scheme with a direct-mapped branch target buffer (BTB). Each BTB entry holds a saturating direction counter and a target. Lookup is combinational in IF and drives the next PC. Updates come from the branch-resolution stage and are written on the clock edge. Built-in performance counters report lookup hits and mispredictions.

---
 rtl/branch_predictor.sv | 87 ++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters and hit/mispredict counters
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              lookup_valid_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] next_pc_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [CTR_W-1:0] WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] WNT = WT - CTR_W'(1);
  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [IDX_W-1:0]  l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic [CTR_W-1:0]  cur_ctr, ctr_d;
  logic [ADDR_W-1:0] tgt_d;
  logic              u_hit, wr;
  logic              unused_lsbs;
  assign unused_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};
  assign l_idx = pc_i[IDX_W+1:2];
  assign l_tag = pc_i[ADDR_W-1:IDX_W+2];
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign hit_o        = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken_o = hit_o && ctr_q[l_idx][CTR_W-1];
  assign next_pc_o    = pred_taken_o ? tgt_q[l_idx] : pc_i + ADDR_W'(4);
  assign hit_cnt_o     = hit_cnt_q;
  assign mispred_cnt_o = mis_cnt_q;
  // A not-taken miss leaves the table alone; only taken misses allocate
  always_comb begin
    cur_ctr   = ctr_q[u_idx];
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    wr        = upd_valid_i && !flush_i && (u_hit || upd_taken_i);
    ctr_d     = !u_hit ? WT
              : upd_taken_i ? ((&cur_ctr) ? cur_ctr : cur_ctr + CTR_W'(1))
              : ((|cur_ctr) ? cur_ctr - CTR_W'(1) : cur_ctr);
    tgt_d     = upd_taken_i ? upd_target_i : tgt_q[u_idx];
    hit_cnt_d = (lookup_valid_i && hit_o && !(&hit_cnt_q)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    mis_cnt_d = (upd_valid_i && upd_mispred_i && !(&mis_cnt_q)) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (wr) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      tgt_q[u_idx]   <= tgt_d;
      ctr_q[u_idx]   <= ctr_d;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
endmodule
